// File: rtl/ram_test_pkg.sv
// Shared types, LED bit map and the test data pattern for the RAM test sequencer.
package ram_test_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_TIMEOUT    = 1023;

    localparam int LED_ERROR     = 7;
    localparam int LED_TOGGLE    = 6;
    localparam int LED_COUNT_MSB = 5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WRITE,
        S_WGAP,
        S_RSTART,
        S_READ,
        S_RGAP,
        S_PASSDONE,
        S_HALT
    } state_t;

    // Seed and address appear both true and inverted so stuck bits show up either way.
    function automatic logic [31:0] pattern(input logic [7:0] a8, input logic [7:0] seed);
        return {seed, a8, ~seed, ~a8};
    endfunction

endpackage

// File: rtl/ram_test_pattern_gen.sv
// Combinational test word for a given word index and pass seed.
module ram_test_pattern_gen
    import ram_test_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] index,
    input  logic [7:0]            seed,
    output logic [31:0]           pattern_out
);

    logic [7:0] a8;

    assign a8          = 8'(index);
    assign pattern_out = pattern(a8, seed);

endmodule

// File: rtl/ram_test_sequencer.sv
// Bus master that writes a seeded pattern to every RAM word, reads it back and
// compares, pass after pass; progress and a sticky error go out on the LEDs.
module ram_test_sequencer
    import ram_test_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        wb_cycle_strobe,
    output logic        wb_write_enable,
    output logic [31:0] wb_address,
    output logic [31:0] wb_write_data,
    input  logic [31:0] wb_read_data,
    input  logic        wb_ack,
    output logic [7:0]  leds,
    output state_t      debug_state
);

    // Handshake: a request is strobe high with we/address/data held stable; it
    // completes at the first rising edge that sees ack high, strobe drops at that
    // edge and stays low for one gap cycle. Ack while strobe is low is ignored.

    localparam int              TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LIMIT = TW'(TIMEOUT);
    localparam logic [TW-1:0]   TMO_ONE   = TW'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] index, index_next;
    logic [7:0]            seed, seed_next;
    logic [15:0]           pass_count, pass_next;
    logic [TW-1:0]         tmo, tmo_next;
    logic [7:0]            leds_next;
    logic [31:0]           write_pattern, expect_pattern;
    logic                  index_last, ack_seen, tmo_expired;

    assign index_last  = &index;
    assign ack_seen    = wb_cycle_strobe & wb_ack;
    assign tmo_expired = (tmo + TMO_ONE) == TMO_LIMIT;
    assign debug_state = state;

    // Write data is registered from the next index/seed; compare uses the current ones.
    ram_test_pattern_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_write_pattern (
        .index       (index_next),
        .seed        (seed_next),
        .pattern_out (write_pattern)
    );

    ram_test_pattern_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_expect_pattern (
        .index       (index),
        .seed        (seed),
        .pattern_out (expect_pattern)
    );

    always_comb begin
        state_next = state;
        index_next = index;
        seed_next  = seed;
        pass_next  = pass_count;
        tmo_next   = tmo;
        leds_next  = leds;
        case (state)
            S_IDLE: begin
                state_next = S_WRITE;
                index_next = '0;
                tmo_next   = '0;
            end
            S_WRITE, S_READ: begin
                if (ack_seen) begin
                    if (state == S_WRITE)
                        state_next = index_last ? S_RSTART : S_WGAP;
                    else if (wb_read_data != expect_pattern)
                        state_next = S_HALT;
                    else
                        state_next = index_last ? S_PASSDONE : S_RGAP;
                end else if (wb_cycle_strobe) begin
                    tmo_next = tmo + TMO_ONE;
                    if (tmo_expired)
                        state_next = S_HALT;
                end
            end
            S_WGAP: begin
                state_next = S_WRITE;
                index_next = index + IDX_ONE;
                tmo_next   = '0;
            end
            S_RSTART: begin
                state_next = S_READ;
                index_next = '0;
                tmo_next   = '0;
            end
            S_RGAP: begin
                state_next = S_READ;
                index_next = index + IDX_ONE;
                tmo_next   = '0;
            end
            S_PASSDONE: begin
                state_next                   = S_WRITE;
                pass_next                    = pass_count + 16'd1;
                seed_next                    = seed + 8'd1;
                index_next                   = '0;
                tmo_next                     = '0;
                leds_next[LED_TOGGLE]        = ~leds[LED_TOGGLE];
                leds_next[LED_COUNT_MSB:0]   = pass_next[5:0];
            end
            S_HALT: begin
                leds_next[LED_ERROR] = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            index           <= '0;
            seed            <= '0;
            pass_count      <= '0;
            tmo             <= '0;
            leds            <= '0;
            wb_cycle_strobe <= 1'b0;
            wb_write_enable <= 1'b0;
            wb_address      <= '0;
            wb_write_data   <= '0;
        end else begin
            state           <= state_next;
            index           <= index_next;
            seed            <= seed_next;
            pass_count      <= pass_next;
            tmo             <= tmo_next;
            leds            <= leds_next;
            wb_cycle_strobe <= (state_next == S_WRITE) || (state_next == S_READ);
            wb_write_enable <= (state_next == S_WRITE);
            if ((state_next == S_WRITE) || (state_next == S_READ))
                wb_address <= 32'(index_next);
            if (state_next == S_WRITE)
                wb_write_data <= write_pattern;
        end
    end

endmodule

// File: tb/tb_ram_test_sequencer.sv
// Bench for ram_test_sequencer: toggle-ack model RAM, expected bus-access queue
// built from the pattern rule, LED/halt/timeout/reset checks.
module tb_ram_test_sequencer;
    import ram_test_pkg::*;

    localparam int AW    = 8;
    localparam int TMO   = 15;
    localparam int WORDS = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic        wb_cycle_strobe, wb_write_enable, wb_ack;
    logic [31:0] wb_address, wb_write_data, wb_read_data;
    logic [7:0]  leds;
    state_t      debug_state;

    ram_test_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .wb_cycle_strobe (wb_cycle_strobe),
        .wb_write_enable (wb_write_enable),
        .wb_address      (wb_address),
        .wb_write_data   (wb_write_data),
        .wb_read_data    (wb_read_data),
        .wb_ack          (wb_ack),
        .leds            (leds),
        .debug_state     (debug_state)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model RAM: ack toggles, read data registered ----------------
    logic [31:0] mem [WORDS];
    logic        ack_r        = 1'b0;
    logic [31:0] rdata        = '0;
    logic        ram_enable   = 1'b1;
    int          corrupt_addr = -1;
    logic        spurious     = 1'b0;
    logic        spur_en      = 1'b0;
    logic        len_check_en = 1'b1;

    always @(posedge clock) begin
        if (ram_enable && wb_cycle_strobe && !ack_r) begin
            ack_r <= 1'b1;
            if (wb_write_enable)
                mem[wb_address[AW-1:0]] <= wb_write_data;
            else
                rdata <= mem[wb_address[AW-1:0]] ^
                         ((int'(wb_address) == corrupt_addr) ? 32'h8 : 32'h0);
        end else begin
            ack_r <= 1'b0;
        end
    end

    assign wb_ack       = ack_r | spurious;
    assign wb_read_data = rdata;

    // Random ack pulses while the strobe is low (gap, idle, halt cycles).
    always @(negedge clock)
        spurious = spur_en && !wb_cycle_strobe && ($urandom_range(0, 2) == 0);

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_pattern(input int a, input int s);
        int sb, ab;
        sb = s % 256;
        ab = a % 256;
        return (32'(sb) << 24) | (32'(ab) << 16) | (32'(255 - sb) << 8) | 32'(255 - ab);
    endfunction

    logic [64:0] exp_q[$];

    // Expected accesses of one pass: every write, then reads 0..last_read.
    task automatic push_pass(input int s, input int last_read);
        for (int a = 0; a < WORDS; a++)
            exp_q.push_back({1'b1, 32'(a), ref_pattern(a, s)});
        for (int a = 0; a <= last_read; a++)
            exp_q.push_back({1'b0, 32'(a), 32'h0});
    endtask

    // ---------------- monitors ----------------
    always @(negedge clock) begin : access_monitor
        logic [64:0] act;
        if (reset_n && wb_cycle_strobe && ack_r) begin
            act = {wb_write_enable, wb_address, wb_write_enable ? wb_write_data : 32'h0};
            if (exp_q.size() == 0) begin
                check("unexpected_access", {31'd0, act}, 96'd0);
            end else begin
                check("bus_access", {31'd0, act}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    int hi_len = 0;
    always @(negedge clock) begin
        if (!reset_n) begin
            hi_len = 0;
        end else if (wb_cycle_strobe) begin
            hi_len++;
        end else begin
            if (hi_len != 0 && len_check_en)
                check("strobe_high_cycles", 96'(hi_len), 96'd2);
            hi_len = 0;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_leds(input logic [7:0] v, input int budget, input string name);
        int n = 0;
        while (leds !== v && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, 96'(leds), 96'(v));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_strobe"}, 96'(wb_cycle_strobe), 96'd0);
        check({tag, "_we"},     96'(wb_write_enable), 96'd0);
        check({tag, "_addr"},   96'(wb_address),      96'd0);
        check({tag, "_wdata"},  96'(wb_write_data),   96'd0);
        check({tag, "_leds"},   96'(leds),            96'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic found;

        // Reset state.
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");

        // Two full passes plus the start of a third, with spurious acks in gaps.
        push_pass(0, WORDS - 1);
        push_pass(1, WORDS - 1);
        push_pass(2, WORDS - 1);
        spur_en = 1'b1;
        reset_n = 1'b1;
        wait_leds(8'h41, 3000, "leds_after_pass1");
        wait_leds(8'h02, 3000, "leds_after_pass2");

        // Asynchronous reset while a read request is outstanding.
        n = 0;
        found = 1'b0;
        while (!found && n < 3000) begin
            @(posedge clock);
            #2;
            n++;
            found = wb_cycle_strobe && !wb_write_enable;
        end
        check("reached_read_pass2", 96'(found), 96'd1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        exp_q.delete();

        // Restart from addr 0 / seed 0; read of 0x37 comes back corrupted.
        corrupt_addr = 'h37;
        push_pass(0, 'h37);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_leds(8'h80, 3000, "leds_mismatch_halt");
        n = 0;
        repeat (100) begin
            @(negedge clock);
            if (wb_cycle_strobe) n++;
        end
        check("halt_no_requests", 96'(n), 96'd0);
        check("halt_leds_frozen", 96'(leds), 96'h80);
        check("halt_queue_drained", 96'(exp_q.size()), 96'd0);

        // Slave never acks: strobe holds TIMEOUT cycles, then error halt.
        reset_n      = 1'b0;
        spur_en      = 1'b0;
        ram_enable   = 1'b0;
        len_check_en = 1'b0;
        corrupt_addr = -1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        while (!wb_cycle_strobe && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("timeout_strobe_rise", 96'(wb_cycle_strobe), 96'd1);
        n = 0;
        while (wb_cycle_strobe && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("timeout_strobe_cycles", 96'(n), 96'(TMO));
        repeat (3) @(negedge clock);
        check("timeout_error_leds", 96'(leds), 96'h80);
        n = 0;
        repeat (20) begin
            @(negedge clock);
            if (wb_cycle_strobe) n++;
        end
        check("timeout_halt_no_requests", 96'(n), 96'd0);
        check("timeout_queue_empty", 96'(exp_q.size()), 96'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
